// File: rtl/branch_resolve.sv
// ID-stage branch/jump resolution: condition evaluation, target generation,
// operand-wait stall, held redirect handshake to fetch, link writeback and statistics.
module branch_resolve #(
  parameter int W     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [2:0]       branchcontrol,
  input  logic             is_j,
  input  logic             is_jr,
  input  logic             link,
  input  logic [W-1:0]     rs_val,
  input  logic [W-1:0]     rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic [W-1:0]     id_pc,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic             if_ready,
  input  logic             flush_exc,
  output logic             id_stall,
  output logic             redirect_valid,
  output logic [W-1:0]     redirect_pc,
  output logic             in_delay_slot,
  output logic             link_we,
  output logic [W-1:0]     link_val,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] BRANCH_EQ  = 3'd1;
  localparam logic [2:0] BRANCH_NEQ = 3'd2;
  localparam logic [2:0] BRANCH_GTZ = 3'd3;
  localparam logic [2:0] BRANCH_LEZ = 3'd4;
  localparam logic [2:0] BRANCH_GEZ = 3'd5;
  localparam logic [2:0] BRANCH_LTZ = 3'd6;

  typedef enum logic [1:0] {IDLE, WAIT_OPND, HOLD} state_e;

  state_e           state_q;
  logic             redirect_valid_q, in_delay_slot_q, link_we_q;
  logic [W-1:0]     redirect_pc_q, link_val_q;
  logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

  logic         is_ctl, needs_rs, needs_rt, opnd_ready, resolve, taken;
  logic [W-1:0] pc_plus4, target;

  assign is_ctl     = id_valid & ((branchcontrol != 3'd0) | is_j | is_jr);
  assign needs_rs   = (branchcontrol != 3'd0) | is_jr;
  assign needs_rt   = (branchcontrol == BRANCH_EQ) | (branchcontrol == BRANCH_NEQ);
  assign opnd_ready = (~needs_rs | rs_ready) & (~needs_rt | rt_ready);
  assign pc_plus4   = id_pc + W'(4);

  // A control instruction arriving while a redirect is still held waits for the handshake.
  assign id_stall = ~flush_exc & is_ctl & ((state_q == HOLD) | ~opnd_ready);
  assign resolve  = ~flush_exc & is_ctl & opnd_ready & (state_q != HOLD);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    taken = 1'b0;
    case (branchcontrol)
      BRANCH_EQ:  taken = (rs_val == rt_val);
      BRANCH_NEQ: taken = (rs_val != rt_val);
      BRANCH_GTZ: taken = ($signed(rs_val) > 0);
      BRANCH_LEZ: taken = ($signed(rs_val) <= 0);
      BRANCH_GEZ: taken = ($signed(rs_val) >= 0);
      BRANCH_LTZ: taken = ($signed(rs_val) < 0);
      default:    taken = 1'b0;
    endcase
    if (is_j | is_jr) taken = 1'b1;

    target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    if (is_jr)     target = rs_val;
    else if (is_j) target = {pc_plus4[31:28], instr_index, 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      in_delay_slot_q  <= 1'b0;
      link_we_q        <= 1'b0;
      link_val_q       <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else if (flush_exc) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      in_delay_slot_q  <= 1'b0;
      link_we_q        <= 1'b0;
    end else begin
      link_we_q <= resolve & link;
      if (resolve & link) link_val_q <= id_pc + W'(8);

      if (resolve)                    in_delay_slot_q <= 1'b1;
      else if (id_valid & ~id_stall)  in_delay_slot_q <= 1'b0;

      case (state_q)
        HOLD: begin
          if (if_ready) begin
            redirect_valid_q <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: begin
          if (resolve) begin
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (taken) begin
              taken_cnt_q      <= taken_cnt_q + CNT_W'(1);
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= target;
              state_q          <= HOLD;
            end else begin
              state_q <= IDLE;
            end
          end else if (is_ctl) begin
            state_q <= WAIT_OPND;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign in_delay_slot  = in_delay_slot_q;
  assign link_we        = link_we_q;
  assign link_val       = link_val_q;
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule
